stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter STK_BASE, default 16'hFFFF: data-memory address of the first (highest) stack slot; the stack grows downward.
REQ-002 Parameter STK_DEPTH, default 256: maximum number of stacked words, with legal range 1..65535.
REQ-003 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port push_req, input, 1: PUSH decoded in ID; level request, held until ack.
REQ-006 Port pop_req, input, 1: POP decoded in ID; level request, held until ack.
REQ-007 Port push_data, input, 16: register value to push, sampled in the accept cycle.
REQ-008 Port flush, input, 1: pipeline flush; cancels any pending or new request.
REQ-009 Port err_clr, input, 1: clears the sticky error flags.
REQ-010 Port dm_rdata, input, 16: data-memory read data, valid the cycle after stk_re.
REQ-011 Port stk_addr, output, 16: data-memory address.
REQ-012 Port stk_wdata, output, 16: data-memory write data.
REQ-013 Ports stk_we and stk_re, output, 1 each: data-memory write strobe and read strobe.
REQ-014 Port pop_data, output, 16: popped word, held until the next pop completes.
REQ-015 Port pop_vld, output, 1: one-cycle pulse when pop_data is updated.
REQ-016 Port ack, output, 1: one-cycle pulse completing a request.
REQ-017 Port stall, output, 1: holds the IM_ID stage while a request is in progress.
REQ-018 Port sp, output, 16: next free slot address.
REQ-019 Port count, output, 16: number of stacked words.
REQ-020 Ports full and empty, output, 1 each: full is count==STK_DEPTH; empty is count==0.
REQ-021 Ports ovf_err and udf_err, output, 1 each: sticky overflow flag and sticky underflow flag.

Function
REQ-022 FSM states SHALL be IDLE, PUSH_WR, POP_RD, POP_WAIT and ERR_ACK.
REQ-023 IDLE, push_req & !flush: latch push_data; go to PUSH_WR if !full, else go to ERR_ACK and set ovf_err.
REQ-024 IDLE, pop_req & !push_req & !flush: go to POP_RD if !empty, else go to ERR_ACK and set udf_err.
REQ-025 When push_req and pop_req are both high, push SHALL win and pop_req SHALL be ignored.
REQ-026 PUSH_WR: stk_we=1, stk_addr=sp, stk_wdata=latched data, ack=1; then sp<=sp-1, count<=count+1, next state IDLE.
REQ-027 POP_RD: stk_re=1, stk_addr=sp+1; next state POP_WAIT.
REQ-028 POP_WAIT: pop_data<=dm_rdata, pop_vld=1, ack=1, sp<=sp+1, count<=count-1; next state IDLE.
REQ-029 ERR_ACK: ack=1 with no strobes, sp and count unchanged, pop_vld=0; next state IDLE.
REQ-030 stall SHALL equal (state!=IDLE & !ack) | (state==IDLE & (push_req|pop_req) & !flush), so stall is low in the ack cycle.
REQ-031 Latency: push acks 1 cycle after the accept cycle; pop acks 2 cycles after the accept cycle.
REQ-032 The requester drops its request in the cycle after ack; a request seen in IDLE in that cycle starts a new operation.
REQ-033 flush in PUSH_WR, POP_RD or POP_WAIT SHALL suppress stk_we, pop_vld and ack, leave sp and count unchanged, and return to IDLE the next cycle.
REQ-034 flush in ERR_ACK SHALL suppress ack and return to IDLE; the error flag stays set.
REQ-035 err_clr SHALL clear both error flags unless a new error is set in the same cycle, in which case set wins.
REQ-036 sp arithmetic SHALL be 16-bit modulo; stk_addr SHALL be driven as 0 when neither strobe is active.

Reset
REQ-037 While rst_n is low, the FSM SHALL go to IDLE and the outputs SHALL be: sp=STK_BASE, count=0, empty=1, full=0, pop_data=0, both error flags 0, and pop_vld, ack, stall, stk_we, stk_re, stk_addr, stk_wdata all 0.
REQ-038 Reset asserted mid-operation SHALL abort it with no memory strobe and no state change beyond the reset values.

Verification
REQ-039 Scenario: after reset, push 0x1234 -> next cycle stk_we=1, stk_addr=0xFFFF, stk_wdata=0x1234, ack=1; then sp=0xFFFE, count=1.
REQ-040 Scenario: push 0xAAAA, push 0x5555, pop -> stk_re at 0xFFFE; 2 cycles after accept pop_data=0x5555, pop_vld=1; then sp=0xFFFE, count=1.
REQ-041 Scenario: with STK_DEPTH=4, four pushes then a fifth -> fifth push gives no stk_we, ovf_err=1, full=1, ack 1 cycle later.
REQ-042 Scenario: pop from empty -> no stk_re, udf_err=1, pop_vld=0, ack 1 cycle later; err_clr then clears udf_err.
REQ-043 Scenario: flush in POP_RD -> no pop_vld, no ack, sp and count unchanged, FSM back in IDLE.
REQ-044 Scenario: rst_n low during PUSH_WR -> stk_we=0, sp=0xFFFF, count=0; simultaneous push_req and pop_req -> only the push is performed.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// Request/acknowledge and data-memory signals of the hardware stack controller.
interface stack_ctrl_if;
  logic        push_req;
  logic        pop_req;
  logic [15:0] push_data;
  logic        flush;
  logic        err_clr;
  logic [15:0] dm_rdata;
  logic [15:0] stk_addr;
  logic [15:0] stk_wdata;
  logic        stk_we;
  logic        stk_re;
  logic [15:0] pop_data;
  logic        pop_vld;
  logic        ack;
  logic        stall;
  logic [15:0] sp;
  logic [15:0] count;
  logic        full;
  logic        empty;
  logic        ovf_err;
  logic        udf_err;

  // Requester / memory side
  modport master (
    output push_req, pop_req, push_data, flush, err_clr, dm_rdata,
    input  stk_addr, stk_wdata, stk_we, stk_re, pop_data, pop_vld, ack, stall,
           sp, count, full, empty, ovf_err, udf_err
  );

  // Stack controller side
  modport slave (
    input  push_req, pop_req, push_data, flush, err_clr, dm_rdata,
    output stk_addr, stk_wdata, stk_we, stk_re, pop_data, pop_vld, ack, stall,
           sp, count, full, empty, ovf_err, udf_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Downward-growing hardware stack in data memory with PUSH/POP handshake,
// pipeline flush and sticky overflow/underflow flags.
module stack_ctrl #(
  parameter logic [15:0] STK_BASE  = 16'hFFFF,
  parameter int unsigned STK_DEPTH = 256
) (
  input logic         clk,
  input logic         rst_n,
  stack_ctrl_if.slave bus
);

  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_WR,
    POP_RD,
    POP_WAIT,
    ERR_ACK
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] sp_q, sp_d;
  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] pop_data_q, pop_data_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          ovf_set, udf_set;

  // Strobes, ack and stall react to flush in the same cycle, so they are decoded
  logic          full_c, empty_c;
  logic          we_c, re_c, ack_c, vld_c, stall_c;
  logic [DW-1:0] addr_c;

  assign full_c  = (count_q == DW'(STK_DEPTH));
  assign empty_c = (count_q == '0);

  // State and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sp_q       <= STK_BASE;
      count_q    <= '0;
      pop_data_q <= '0;
      wdata_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      count_q    <= count_d;
      pop_data_q <= pop_data_d;
      wdata_q    <= wdata_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Next-state, register updates and cycle outputs
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    count_d    = count_q;
    pop_data_d = pop_data_q;
    wdata_d    = wdata_q;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    we_c       = 1'b0;
    re_c       = 1'b0;
    ack_c      = 1'b0;
    vld_c      = 1'b0;
    addr_c     = '0;

    unique case (state_q)
      IDLE: begin
        // Push has priority over a simultaneous pop
        if (bus.push_req && !bus.flush) begin
          wdata_d = bus.push_data;
          if (full_c) begin
            state_d = ERR_ACK;
            ovf_set = 1'b1;
          end else begin
            state_d = PUSH_WR;
          end
        end else if (bus.pop_req && !bus.flush) begin
          if (empty_c) begin
            state_d = ERR_ACK;
            udf_set = 1'b1;
          end else begin
            state_d = POP_RD;
          end
        end
      end
      PUSH_WR: begin
        state_d = IDLE;
        if (!bus.flush) begin
          we_c    = 1'b1;
          addr_c  = sp_q;
          ack_c   = 1'b1;
          sp_d    = sp_q - DW'(1);
          count_d = count_q + DW'(1);
        end
      end
      POP_RD: begin
        re_c    = 1'b1;
        addr_c  = sp_q + DW'(1);
        state_d = bus.flush ? IDLE : POP_WAIT;
      end
      POP_WAIT: begin
        state_d = IDLE;
        if (!bus.flush) begin
          pop_data_d = bus.dm_rdata;
          vld_c      = 1'b1;
          ack_c      = 1'b1;
          sp_d       = sp_q + DW'(1);
          count_d    = count_q - DW'(1);
        end
      end
      ERR_ACK: begin
        state_d = IDLE;
        ack_c   = !bus.flush;
      end
      default: state_d = IDLE;
    endcase

    // Sticky flags: a new error in the same cycle beats err_clr
    ovf_d = ovf_set | (ovf_q & !bus.err_clr);
    udf_d = udf_set | (udf_q & !bus.err_clr);
  end

  // Hold the IM_ID stage until the ack cycle; forced low while in reset
  assign stall_c = rst_n &
                   (((state_q != IDLE) && !ack_c) ||
                    ((state_q == IDLE) && (bus.push_req || bus.pop_req) && !bus.flush));

  assign bus.stk_we    = we_c;
  assign bus.stk_re    = re_c;
  assign bus.stk_addr  = addr_c;
  assign bus.stk_wdata = we_c ? wdata_q : '0;
  assign bus.pop_data  = vld_c ? bus.dm_rdata : pop_data_q;
  assign bus.pop_vld   = vld_c;
  assign bus.ack       = ack_c;
  assign bus.stall     = stall_c;
  assign bus.sp        = sp_q;
  assign bus.count     = count_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.ovf_err   = ovf_q;
  assign bus.udf_err   = udf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a queue-based reference model checked every cycle.
module tb_stack_ctrl;

  localparam int DEPTH = 4;
  localparam int BASE  = 16'hFFFF;
  localparam int OP_NONE = 0, OP_PUSH = 1, OP_POP = 2, OP_ERR = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  stack_ctrl_if ifc ();

  stack_ctrl #(.STK_BASE(16'hFFFF), .STK_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, read data valid the cycle after stk_re
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (ifc.stk_we) mem[ifc.stk_addr] <= ifc.stk_wdata;
    if (ifc.stk_re) ifc.dm_rdata <= mem[ifc.stk_addr];
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stack contents as a queue plus the operation in flight
  logic [15:0] q[$];
  int          op = OP_NONE;
  int          age = 0;
  logic [15:0] m_lat = '0;
  logic [15:0] m_pop = '0;
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      op = OP_NONE; age = 0; m_lat = '0; m_pop = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      logic so, su;
      so = 1'b0; su = 1'b0;
      case (op)
        OP_NONE: begin
          if (ifc.push_req && !ifc.flush) begin
            m_lat = ifc.push_data;
            if (q.size() == DEPTH) begin op = OP_ERR; so = 1'b1; end
            else op = OP_PUSH;
            age = 1;
          end else if (ifc.pop_req && !ifc.flush) begin
            if (q.size() == 0) begin op = OP_ERR; su = 1'b1; end
            else op = OP_POP;
            age = 1;
          end
        end
        OP_PUSH: begin
          if (!ifc.flush) q.push_back(m_lat);
          op = OP_NONE;
        end
        OP_POP: begin
          if (age == 1) begin
            if (ifc.flush) op = OP_NONE; else age = 2;
          end else begin
            if (!ifc.flush) m_pop = q.pop_back();
            op = OP_NONE;
          end
        end
        default: op = OP_NONE;
      endcase
      m_ovf = so | (m_ovf & !ifc.err_clr);
      m_udf = su | (m_udf & !ifc.err_clr);
    end
  end

  // Every-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    logic        e_ack, e_we, e_re, e_vld, e_stall;
    logic [15:0] e_addr, e_pop;
    e_we   = (op == OP_PUSH) && !ifc.flush;
    e_re   = (op == OP_POP) && (age == 1);
    e_vld  = (op == OP_POP) && (age == 2) && !ifc.flush;
    e_ack  = e_we || e_vld || ((op == OP_ERR) && !ifc.flush);
    e_addr = e_we ? 16'(BASE - q.size()) : e_re ? 16'(BASE - q.size() + 1) : 16'h0000;
    e_pop  = e_vld ? q[q.size()-1] : m_pop;
    e_stall = rst_n && (((op != OP_NONE) && !e_ack) ||
                        ((op == OP_NONE) && (ifc.push_req || ifc.pop_req) && !ifc.flush));
    chk("ack",      16'(ifc.ack),     16'(e_ack));
    chk("stk_we",   16'(ifc.stk_we),  16'(e_we));
    chk("stk_re",   16'(ifc.stk_re),  16'(e_re));
    chk("stk_addr", ifc.stk_addr,     e_addr);
    chk("stk_wdata", ifc.stk_wdata,   e_we ? m_lat : 16'h0000);
    chk("pop_vld",  16'(ifc.pop_vld), 16'(e_vld));
    chk("pop_data", ifc.pop_data,     e_pop);
    chk("stall",    16'(ifc.stall),   16'(e_stall));
    chk("sp",       ifc.sp,           16'(BASE - q.size()));
    chk("count",    ifc.count,        16'(q.size()));
    chk("full",     16'(ifc.full),    16'(q.size() == DEPTH));
    chk("empty",    16'(ifc.empty),   16'(q.size() == 0));
    chk("ovf_err",  16'(ifc.ovf_err), 16'(m_ovf));
    chk("udf_err",  16'(ifc.udf_err), 16'(m_udf));
  end

  // Issue one request, hold it until ack, report what the ack cycle looked like
  task automatic req(input logic push, input logic pop, input logic [15:0] data,
                     output int lat, output logic a_we, output logic a_vld,
                     output logic [15:0] a_addr, output logic [15:0] a_wdata,
                     output logic [15:0] a_pd, output logic re_seen,
                     output logic [15:0] re_addr);
    bit got;
    got = 0; lat = 0; re_seen = 1'b0; re_addr = '0;
    a_we = 1'b0; a_vld = 1'b0; a_addr = '0; a_wdata = '0; a_pd = '0;
    @(posedge clk); #1;
    ifc.push_req = push; ifc.pop_req = pop; ifc.push_data = data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifc.stk_re) begin re_seen = 1'b1; re_addr = ifc.stk_addr; end
      if (ifc.ack) begin
        a_we = ifc.stk_we; a_vld = ifc.pop_vld; a_addr = ifc.stk_addr;
        a_wdata = ifc.stk_wdata; a_pd = ifc.pop_data;
        got = 1;
        break;
      end
      lat++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 10 cycles");
    end
    @(posedge clk); #1;
    ifc.push_req = 1'b0; ifc.pop_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    int          lat;
    logic        a_we, a_vld, re_seen;
    logic [15:0] a_addr, a_wdata, a_pd, re_addr;

    rst_n = 1'b0;
    ifc.push_req = 1'b0; ifc.pop_req = 1'b0; ifc.push_data = '0;
    ifc.flush = 1'b0; ifc.err_clr = 1'b0; ifc.dm_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sp", ifc.sp, 16'hFFFF);
    chk("rst_empty", 16'(ifc.empty), 16'd1);
    rst_n = 1'b1;

    // Single push
    req(1'b1, 1'b0, 16'h1234, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    chk("push_lat", 16'(lat), 16'd1);
    chk("push_we", 16'(a_we), 16'd1);
    chk("push_addr", a_addr, 16'hFFFF);
    chk("push_wdata", a_wdata, 16'h1234);
    chk("push_sp", ifc.sp, 16'hFFFE);
    chk("push_count", ifc.count, 16'd1);

    // Push, push, pop returns the last word
    do_reset();
    req(1'b1, 1'b0, 16'hAAAA, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    req(1'b1, 1'b0, 16'h5555, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    req(1'b0, 1'b1, 16'h0000, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    chk("pop_lat", 16'(lat), 16'd2);
    chk("pop_re_addr", re_addr, 16'hFFFE);
    chk("pop_data", a_pd, 16'h5555);
    chk("pop_vld", 16'(a_vld), 16'd1);
    chk("pop_sp", ifc.sp, 16'hFFFE);
    chk("pop_count", ifc.count, 16'd1);

    // Fill to depth, overflow, then drain in LIFO order
    do_reset();
    for (int i = 1; i <= DEPTH; i++)
      req(1'b1, 1'b0, 16'(16'h0100 * i), lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    chk("fill_full", 16'(ifc.full), 16'd1);
    req(1'b1, 1'b0, 16'h9999, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    chk("ovf_lat", 16'(lat), 16'd1);
    chk("ovf_no_we", 16'(a_we), 16'd0);
    chk("ovf_flag", 16'(ifc.ovf_err), 16'd1);
    chk("ovf_full", 16'(ifc.full), 16'd1);
    chk("ovf_count", ifc.count, 16'd4);
    for (int i = DEPTH; i >= 1; i--) begin
      req(1'b0, 1'b1, 16'h0000, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
      chk("drain_data", a_pd, 16'(16'h0100 * i));
    end

    // Pop from empty, then clear flags
    req(1'b0, 1'b1, 16'h0000, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    chk("udf_lat", 16'(lat), 16'd1);
    chk("udf_no_re", 16'(re_seen), 16'd0);
    chk("udf_no_vld", 16'(a_vld), 16'd0);
    chk("udf_flag", 16'(ifc.udf_err), 16'd1);
    ifc.err_clr = 1'b1;
    @(posedge clk); #1 ifc.err_clr = 1'b0;
    chk("clr_udf", 16'(ifc.udf_err), 16'd0);
    chk("clr_ovf", 16'(ifc.ovf_err), 16'd0);

    // Flush while the pop read is outstanding
    req(1'b1, 1'b0, 16'h0BEE, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    ifc.pop_req = 1'b1;
    @(posedge clk); #1;
    ifc.pop_req = 1'b0; ifc.flush = 1'b1;
    @(negedge clk);
    chk("flush_ack", 16'(ifc.ack), 16'd0);
    chk("flush_vld", 16'(ifc.pop_vld), 16'd0);
    @(posedge clk); #1 ifc.flush = 1'b0;
    chk("flush_count", ifc.count, 16'd1);
    chk("flush_sp", ifc.sp, 16'hFFFE);
    @(negedge clk);
    chk("flush_idle", 16'(ifc.stall), 16'd0);
    req(1'b0, 1'b1, 16'h0000, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    chk("after_flush_pop", a_pd, 16'h0BEE);

    // Reset asserted in the push write cycle
    @(posedge clk); #1 ifc.push_req = 1'b1; ifc.push_data = 16'h7777;
    @(posedge clk); #1 rst_n = 1'b0; ifc.push_req = 1'b0;
    #1;
    chk("rstmid_we", 16'(ifc.stk_we), 16'd0);
    chk("rstmid_sp", ifc.sp, 16'hFFFF);
    chk("rstmid_count", ifc.count, 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Simultaneous push and pop: push wins
    req(1'b1, 1'b1, 16'h4242, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    chk("both_lat", 16'(lat), 16'd1);
    chk("both_we", 16'(a_we), 16'd1);
    chk("both_vld", 16'(a_vld), 16'd0);
    chk("both_count", ifc.count, 16'd1);
    req(1'b0, 1'b1, 16'h0000, lat, a_we, a_vld, a_addr, a_wdata, a_pd, re_seen, re_addr);
    chk("both_pop", a_pd, 16'h4242);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
